// File: rtl/fft_dtmf_peak_scan.sv
// Post-processor for the streaming FFT of the DTMF detector.
// Computes |re|+|im| for each bin and tracks the strongest bin in a low
// and a high tone window. It reports both peaks, with a threshold detect
// flag, once per completed frame.
module fft_dtmf_peak_scan #(
    parameter int IWIDTH = 8,
    parameter int LGFFT  = 8,
    parameter int LO_MIN = 20,
    parameter int LO_MAX = 32,
    parameter int HI_MIN = 36,
    parameter int HI_MAX = 55,
    parameter logic [IWIDTH:0] THRESH = 64
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_ce,
    input  logic [2*IWIDTH-1:0]   i_result,
    input  logic                  i_sync,
    output logic [IWIDTH:0]       o_mag,
    output logic [LGFFT-1:0]      o_bin,
    output logic                  o_mag_valid,
    output logic [LGFFT-1:0]      o_lo_bin,
    output logic [LGFFT-1:0]      o_hi_bin,
    output logic [IWIDTH:0]       o_lo_mag,
    output logic [IWIDTH:0]       o_hi_mag,
    output logic                  o_detect,
    output logic                  o_frame_valid,
    output logic                  o_resync
);

    localparam logic [LGFFT-1:0] LAST     = '1;
    localparam logic [LGFFT-1:0] LO_MIN_B = LGFFT'(LO_MIN);
    localparam logic [LGFFT-1:0] LO_MAX_B = LGFFT'(LO_MAX);
    localparam logic [LGFFT-1:0] HI_MIN_B = LGFFT'(HI_MIN);
    localparam logic [LGFFT-1:0] HI_MAX_B = LGFFT'(HI_MAX);

    // Absolute value of a two's complement component; the most negative
    // value maps to 2^(IWIDTH-1), which still fits unsigned in IWIDTH bits.
    function automatic logic [IWIDTH-1:0] abs_comp(input logic [IWIDTH-1:0] x);
        logic [IWIDTH-1:0] u;
        u = x;
        return u[IWIDTH-1] ? (~u + 1'b1) : u;
    endfunction

    // Exact |re|+|im| with one growth bit.
    function automatic logic [IWIDTH:0] bin_mag(input logic [2*IWIDTH-1:0] r);
        return {1'b0, abs_comp(r[2*IWIDTH-1:IWIDTH])} + {1'b0, abs_comp(r[IWIDTH-1:0])};
    endfunction

    typedef enum logic {UNSYNC, SCAN} state_t;

    state_t              state, state_nxt;
    logic [LGFFT-1:0]    cnt, bin_nxt;
    logic                accept, early_sync;

    logic [2*IWIDTH-1:0] res_p0;
    logic [LGFFT-1:0]    bin_p0;
    logic                vld_p0, resync_p0;

    logic [IWIDTH:0]     lo_mag_p2, hi_mag_p2, lo_mag_nxt, hi_mag_nxt;
    logic [LGFFT-1:0]    lo_bin_p2, hi_bin_p2, lo_bin_nxt, hi_bin_nxt;

    // Frame acquisition: decide whether this bin is accepted and its index.
    always_comb begin
        state_nxt  = state;
        accept     = 1'b0;
        early_sync = 1'b0;
        bin_nxt    = cnt;
        case (state)
            UNSYNC: begin
                if (i_ce && i_sync) begin
                    state_nxt = SCAN;
                    accept    = 1'b1;
                    bin_nxt   = '0;
                end
            end
            SCAN: begin
                if (i_ce) begin
                    accept = 1'b1;
                    if (i_sync) begin
                        bin_nxt    = '0;
                        early_sync = (cnt != LAST);
                    end else begin
                        bin_nxt = cnt + 1'b1;
                    end
                end
            end
            default: state_nxt = UNSYNC;
        endcase
    end

    // State register and bin counter.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= UNSYNC;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (accept)
                cnt <= bin_nxt;
        end
    end

    // ---- stage 0: capture accepted bin with its index ----
    // Register the raw bin so the magnitude adder sees a clean input.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            res_p0    <= '0;
            bin_p0    <= '0;
            vld_p0    <= 1'b0;
            resync_p0 <= 1'b0;
        end else begin
            vld_p0    <= accept;
            resync_p0 <= early_sync;
            if (accept) begin
                res_p0 <= i_result;
                bin_p0 <= bin_nxt;
            end
        end
    end

    // ---- stage 1: per-bin magnitude ----
    // Magnitude output stage; also carries the resync pulse.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_mag       <= '0;
            o_bin       <= '0;
            o_mag_valid <= 1'b0;
            o_resync    <= 1'b0;
        end else begin
            o_mag_valid <= vld_p0;
            o_resync    <= resync_p0;
            if (vld_p0) begin
                o_mag <= bin_mag(res_p0);
                o_bin <= bin_p0;
            end
        end
    end

    // Window trackers: the first bin of a window loads, later bins replace only when strictly larger.
    always_comb begin
        lo_mag_nxt = lo_mag_p2;
        lo_bin_nxt = lo_bin_p2;
        hi_mag_nxt = hi_mag_p2;
        hi_bin_nxt = hi_bin_p2;
        if (o_bin == LO_MIN_B ||
            (o_bin > LO_MIN_B && o_bin <= LO_MAX_B && o_mag > lo_mag_p2)) begin
            lo_mag_nxt = o_mag;
            lo_bin_nxt = o_bin;
        end
        if (o_bin == HI_MIN_B ||
            (o_bin > HI_MIN_B && o_bin <= HI_MAX_B && o_mag > hi_mag_p2)) begin
            hi_mag_nxt = o_mag;
            hi_bin_nxt = o_bin;
        end
    end

    // ---- stage 2: peak tracking and end-of-frame report ----
    // Update trackers, and on the last bin publish the frame result.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            lo_mag_p2     <= '0;
            lo_bin_p2     <= '0;
            hi_mag_p2     <= '0;
            hi_bin_p2     <= '0;
            o_lo_bin      <= '0;
            o_hi_bin      <= '0;
            o_lo_mag      <= '0;
            o_hi_mag      <= '0;
            o_detect      <= 1'b0;
            o_frame_valid <= 1'b0;
        end else begin
            o_frame_valid <= 1'b0;
            if (o_mag_valid) begin
                lo_mag_p2 <= lo_mag_nxt;
                lo_bin_p2 <= lo_bin_nxt;
                hi_mag_p2 <= hi_mag_nxt;
                hi_bin_p2 <= hi_bin_nxt;
                if (o_bin == LAST) begin
                    o_lo_bin      <= lo_bin_nxt;
                    o_lo_mag      <= lo_mag_nxt;
                    o_hi_bin      <= hi_bin_nxt;
                    o_hi_mag      <= hi_mag_nxt;
                    o_detect      <= (lo_mag_nxt >= THRESH) && (hi_mag_nxt >= THRESH);
                    o_frame_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_fft_dtmf_peak_scan.sv
// Bench for fft_dtmf_peak_scan: table-driven frames, hand-written corner
// sequences and randomized frames checked against a behavioural model.
module tb_fft_dtmf_peak_scan;

    localparam int IW = 8;
    localparam int LG = 8;
    localparam int N  = 256;
    localparam int LO_MIN = 20, LO_MAX = 32, HI_MIN = 36, HI_MAX = 55, THR = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          ce = 1'b0;
    logic          sync = 1'b0;
    logic [2*IW-1:0] result = '0;
    logic [IW:0]   o_mag, o_lo_mag, o_hi_mag;
    logic [LG-1:0] o_bin, o_lo_bin, o_hi_bin;
    logic          o_mag_valid, o_detect, o_frame_valid, o_resync;

    fft_dtmf_peak_scan #(
        .IWIDTH(IW), .LGFFT(LG), .LO_MIN(LO_MIN), .LO_MAX(LO_MAX),
        .HI_MIN(HI_MIN), .HI_MAX(HI_MAX), .THRESH(9'd64)
    ) dut (
        .i_clk(clk), .i_reset(rst), .i_ce(ce), .i_result(result), .i_sync(sync),
        .o_mag(o_mag), .o_bin(o_bin), .o_mag_valid(o_mag_valid),
        .o_lo_bin(o_lo_bin), .o_hi_bin(o_hi_bin), .o_lo_mag(o_lo_mag),
        .o_hi_mag(o_hi_mag), .o_detect(o_detect), .o_frame_valid(o_frame_valid),
        .o_resync(o_resync)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    typedef struct {
        int lo_bin, lo_mag, hi_bin, hi_mag, det;
    } fres_t;

    bit    m_sync = 0;
    int    m_cnt = 0;
    int    cur_re[N];
    int    cur_im[N];
    int    q_mag[$];
    int    q_bin[$];
    fres_t q_frm[$];
    int    exp_resync = 0;
    int    got_resync = 0;
    int    n_frames = 0;
    int    frm_cyc[$];

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    function automatic int mag_of(input int b);
        return iabs(cur_re[b]) + iabs(cur_im[b]);
    endfunction

    // Strongest bin in each window; first occurrence wins on ties.
    function automatic fres_t ref_frame();
        fres_t r;
        r.lo_bin = LO_MIN; r.lo_mag = mag_of(LO_MIN);
        for (int b = LO_MIN + 1; b <= LO_MAX; b++)
            if (mag_of(b) > r.lo_mag) begin r.lo_mag = mag_of(b); r.lo_bin = b; end
        r.hi_bin = HI_MIN; r.hi_mag = mag_of(HI_MIN);
        for (int b = HI_MIN + 1; b <= HI_MAX; b++)
            if (mag_of(b) > r.hi_mag) begin r.hi_mag = mag_of(b); r.hi_bin = b; end
        r.det = (r.lo_mag >= THR && r.hi_mag >= THR) ? 1 : 0;
        return r;
    endfunction

    // Drive one cycle of input and advance the model.
    task automatic send(input bit c, input bit s, input int re, input int im);
        int  idx;
        bit  acc;
        idx = 0;
        acc = 0;
        @(negedge clk);
        ce = c; sync = s; result = {re[7:0], im[7:0]};
        @(posedge clk);
        if (c) begin
            if (!m_sync) begin
                if (s) begin m_sync = 1; acc = 1; idx = 0; end
            end else begin
                acc = 1;
                if (s) begin
                    if (m_cnt != N - 1) exp_resync++;
                    idx = 0;
                end else begin
                    idx = (m_cnt + 1) % N;
                end
            end
            if (acc) begin
                m_cnt = idx;
                cur_re[idx] = re;
                cur_im[idx] = im;
                q_mag.push_back(iabs(re) + iabs(im));
                q_bin.push_back(idx);
                if (idx == N - 1) q_frm.push_back(ref_frame());
            end
        end
    endtask

    function automatic int rnd_s8();
        return int'($urandom_range(0, 255)) - 128;
    endfunction

    // Continuous output monitor against the model queues.
    always @(negedge clk) begin
        if (!rst) begin
            if (o_mag_valid) begin
                if (q_mag.size() == 0) check("mag_unexpected_valid", 1, 0);
                else begin
                    check("mag_stream", int'(o_mag), q_mag.pop_front());
                    check("bin_stream", int'(o_bin), q_bin.pop_front());
                end
            end
            if (o_frame_valid) begin
                n_frames++;
                frm_cyc.push_back(cyc);
                if (q_frm.size() == 0) check("frame_unexpected", 1, 0);
                else begin
                    fres_t e;
                    e = q_frm.pop_front();
                    check("model_lo_bin", int'(o_lo_bin), e.lo_bin);
                    check("model_lo_mag", int'(o_lo_mag), e.lo_mag);
                    check("model_hi_bin", int'(o_hi_bin), e.hi_bin);
                    check("model_hi_mag", int'(o_hi_mag), e.hi_mag);
                    check("model_detect", int'(o_detect), e.det);
                end
            end
            if (o_resync) got_resync++;
        end
    end

    // ---------------- frame vector table ----------------
    typedef struct {
        int b0, r0, i0, b1, r1, i1, b2, r2, i2;
        int lo_bin, lo_mag, hi_bin, hi_mag, det;
    } vec_t;

    vec_t tab[7];

    task automatic send_frame(input bit s0, input int gapmax, input bit use_tab, input int ti);
        for (int b = 0; b < N; b++) begin
            int re, im;
            repeat ($urandom_range(0, gapmax)) send(1'b0, 1'($urandom_range(0, 1)), rnd_s8(), rnd_s8());
            if (use_tab) begin
                re = 0; im = 0;
                if (b == tab[ti].b0) begin re = tab[ti].r0; im = tab[ti].i0; end
                if (b == tab[ti].b1) begin re = tab[ti].r1; im = tab[ti].i1; end
                if (b == tab[ti].b2) begin re = tab[ti].r2; im = tab[ti].i2; end
            end else begin
                re = rnd_s8(); im = rnd_s8();
            end
            send(1'b1, (b == 0) ? s0 : 1'b0, re, im);
        end
    endtask

    // Full table frame with exact end-of-frame timing checks.
    task automatic apply_tab(input int ti);
        send_frame(1'b1, 0, 1'b1, ti);
        send(1'b0, 1'b0, 0, 0);
        #1 check("tab_fv_not_yet", int'(o_frame_valid), 0);
        send(1'b0, 1'b0, 0, 0);
        #1;
        check("tab_fv_pulse", int'(o_frame_valid), 1);
        check("tab_lo_bin", int'(o_lo_bin), tab[ti].lo_bin);
        check("tab_lo_mag", int'(o_lo_mag), tab[ti].lo_mag);
        check("tab_hi_bin", int'(o_hi_bin), tab[ti].hi_bin);
        check("tab_hi_mag", int'(o_hi_mag), tab[ti].hi_mag);
        check("tab_detect", int'(o_detect), tab[ti].det);
        send(1'b0, 1'b0, 0, 0);
        #1;
        check("tab_fv_one_cycle", int'(o_frame_valid), 0);
        check("tab_lo_bin_hold", int'(o_lo_bin), tab[ti].lo_bin);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mag"}, int'(o_mag), 0);
        check({tag, "_bin"}, int'(o_bin), 0);
        check({tag, "_mag_valid"}, int'(o_mag_valid), 0);
        check({tag, "_lo_bin"}, int'(o_lo_bin), 0);
        check({tag, "_hi_bin"}, int'(o_hi_bin), 0);
        check({tag, "_lo_mag"}, int'(o_lo_mag), 0);
        check({tag, "_hi_mag"}, int'(o_hi_mag), 0);
        check({tag, "_detect"}, int'(o_detect), 0);
        check({tag, "_frame_valid"}, int'(o_frame_valid), 0);
        check({tag, "_resync"}, int'(o_resync), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        q_mag.delete(); q_bin.delete(); q_frm.delete();
        m_sync = 0; m_cnt = 0;
        #1 check_all_zero("reset_mid");
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int fb, last;
        tab[0] = '{26, 40, -30,   43, -128, 5,    0, 0, 0,       26, 70, 43, 133, 1};
        tab[1] = '{26, 40, -30,   45, 50, 0,      0, 0, 0,       26, 70, 45, 50, 0};
        tab[2] = '{38, 20, 10,    40, -15, -15,   0, 0, 0,       20, 0, 38, 30, 0};
        tab[3] = '{32, -128, -128, 55, 127, -128, 19, 127, 127,  32, 256, 55, 255, 1};
        tab[4] = '{20, 64, 0,     36, 0, -64,     0, 0, 0,       20, 64, 36, 64, 1};
        tab[5] = '{20, 63, 0,     36, 0, 64,      56, 100, 100,  20, 63, 36, 64, 0};
        tab[6] = '{31, 10, 0,     56, 100, 100,   35, -50, 50,   31, 10, 36, 0, 0};

        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;

        // Unsynced bins are dropped; first sync bin appears one cycle later as bin 0.
        for (int i = 0; i < 5; i++) send(1'b1, 1'b0, rnd_s8(), rnd_s8());
        send(1'b1, 1'b1, 40, -30);
        #1 check("unsync_no_valid", int'(o_mag_valid), 0);
        send(1'b0, 1'b0, 0, 0);
        #1;
        check("first_sync_valid", int'(o_mag_valid), 1);
        check("first_sync_bin", int'(o_bin), 0);
        check("first_sync_mag", int'(o_mag), 70);

        for (int ti = 0; ti < 7; ti++) apply_tab(ti);

        // Early sync at bin 100 aborts the frame.
        fb = n_frames;
        for (int b = 0; b < 100; b++) send(1'b1, b == 0, rnd_s8(), rnd_s8());
        send(1'b1, 1'b1, rnd_s8(), rnd_s8());
        #1 check("resync_not_yet", int'(o_resync), 0);
        send(1'b0, 1'b0, 0, 0);
        #1 check("resync_pulse", int'(o_resync), 1);
        send(1'b0, 1'b0, 0, 0);
        #1 check("resync_one_cycle", int'(o_resync), 0);
        for (int b = 1; b < N; b++) send(1'b1, 1'b0, rnd_s8(), rnd_s8());
        repeat (4) send(1'b0, 1'b0, 0, 0);
        check("early_sync_frames", n_frames - fb, 1);

        // Three contiguous frames, random gaps in the second, wrap start for it.
        fb = n_frames;
        send_frame(1'b1, 0, 1'b0, 0);
        send_frame(1'b0, 3, 1'b0, 0);
        send_frame(1'b1, 0, 1'b0, 0);
        repeat (4) send(1'b0, 1'b0, 0, 0);
        check("three_frame_pulses", n_frames - fb, 3);
        last = frm_cyc.size() - 1;
        if (last >= 1) check("full_rate_period", frm_cyc[last] - frm_cyc[last - 1], N);
        else check("full_rate_period_missing", last, 1);

        // Reset at bin 150, then re-acquisition.
        for (int b = 0; b <= 150; b++) send(1'b1, b == 0, rnd_s8(), rnd_s8());
        do_reset();
        for (int i = 0; i < 4; i++) send(1'b1, 1'b0, rnd_s8(), rnd_s8());
        #1 check("post_reset_unsync", int'(o_mag_valid), 0);
        apply_tab(0);

        repeat (3) send(1'b0, 1'b0, 0, 0);
        check("mag_queue_drained", q_mag.size(), 0);
        check("frame_queue_drained", q_frm.size(), 0);
        check("resync_count", got_resync, exp_resync);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/fft_dtmf_peak_scan.md
# fft_dtmf_peak_scan

Parametrised post-processor for the DTMF detector's streaming FFT output. It consumes one complex bin per clock-enable, aligned to the FFT's frame sync, and computes a per-bin magnitude approximation (|re|+|im|). Within each frame it tracks the strongest bin in a low-group window and a high-group window, then reports both peaks with a threshold-qualified detect flag once per frame. It sits directly downstream of the FFT core and feeds the tone-decision logic.

## Interface
- IWIDTH, 8: width of each signed real/imag component of an FFT bin
- LGFFT, 8: log2 of FFT size N (bins per frame)
- LO_MIN, 20 / LO_MAX, 32: inclusive low-group bin window (697–941 Hz at 8 kHz, N=256)
- HI_MIN, 36 / HI_MAX, 55: inclusive high-group bin window (1209–1633 Hz)
- THRESH, 64: minimum peak magnitude for detect; width IWIDTH+1
- Legal only if LO_MIN<=LO_MAX<HI_MIN<=HI_MAX<=N-1
- i_clk  in  1  system clock; all logic on rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_ce  in  1  bin-valid strobe; one bin accepted per cycle with i_ce=1
- i_result  in  2*IWIDTH  bin: real in [2*IWIDTH-1:IWIDTH], imag in [IWIDTH-1:0], two's complement
- i_sync  in  1  qualified by i_ce; marks bin 0 of a frame
- o_mag  out  IWIDTH+1  |re|+|im| of the last accepted bin
- o_bin  out  LGFFT  bin index of o_mag
- o_mag_valid  out  1  o_mag/o_bin updated this cycle
- o_lo_bin, o_hi_bin  out  LGFFT  peak bin of each window, last completed frame
- o_lo_mag, o_hi_mag  out  IWIDTH+1  peak magnitudes, last completed frame
- o_detect  out  1  o_lo_mag>=THRESH and o_hi_mag>=THRESH
- o_frame_valid  out  1  one-cycle pulse: frame outputs just updated
- o_resync  out  1  one-cycle pulse: frame aborted by early sync

## Operation
- States: UNSYNC (reset), SCAN. In UNSYNC all i_ce bins are discarded until i_ce&i_sync; that bin is index 0 and state goes to SCAN.
- Bin counter (LGFFT bits) in SCAN: i_ce&i_sync loads 0; i_ce alone increments and wraps N-1->0. A wrap without sync starts a new frame normally (frames are contiguous).
- Early sync: i_ce&i_sync while counter!=N-1 (mid-frame): current frame discarded, no o_frame_valid, o_resync pulses, new frame starts at bin 0. Sync after bin N-1 is the normal case.
- Magnitude: abs of each component as IWIDTH-bit unsigned (-2^(IWIDTH-1) maps to 2^(IWIDTH-1), no saturation), sum IWIDTH+1 bits, exact.
- Peak tracking per window: bin==MIN loads tracker unconditionally (mag and bin); MIN<bin<=MAX replaces only if mag strictly greater (ties keep lower bin). Bins outside windows ignored.
- At bin N-1, final peaks (including bin N-1 if in a window) latch into o_lo_*/o_hi_*, o_detect computed from them, o_frame_valid pulses. Frame outputs hold until the next completed frame.
- i_ce gaps of any length are allowed; the pipeline is free-running and only acts on valid stages.

## Timing
- Reset: all outputs 0, state UNSYNC, counter 0, trackers 0.
- Stage 1: bin accepted at edge k -> o_mag, o_bin, o_mag_valid=1 visible after edge k+1 (one cycle wide per bin).
- Stage 2: trackers update at edge k+2; for bin N-1, o_frame_valid/o_detect/peak outputs visible after edge k+2, valid pulse one cycle.
- o_resync visible after edge k+1 for the early-sync bin at edge k.
- Back-to-back frames at full rate (i_ce=1 continuously): one o_frame_valid every N cycles, no bubbles.
- Reset asserted mid-frame: in-flight stages cleared immediately, no pulse emitted; re-acquisition requires a new sync.

## Test plan
- Reset then bins with i_sync=0 only -> o_mag_valid stays 0, no o_frame_valid; first sync bin -> o_mag_valid 1 cycle later with o_bin=0.
- Full frame, all bins 0 except bin 26 = (40,-30) and bin 43 = (-128,5) -> o_lo_bin=26, o_lo_mag=70, o_hi_bin=43, o_hi_mag=133, o_detect=1, o_frame_valid 2 cycles after bin 255.
- Low peak 70 but high-window max 50 -> o_detect=0, peaks still reported; equal maxima at bins 38 and 40 -> o_hi_bin=38.
- Early sync at bin 100 -> o_resync pulse, no o_frame_valid, following full frame reports correctly from new sync.
- Continuous i_ce over 3 frames with random i_ce gaps in frame 2 -> exactly 3 pulses, results match reference model; reset at bin 150 -> all outputs 0, UNSYNC.
